// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: tracked-entry struct and latency constants.
package fwd_pkg;

    localparam int RD_W       = 5;
    localparam int LAT_ALU    = 1;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic            v;
        logic            wr;
        logic            mul;
        logic [RD_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/fwd_scoreboard_unit_if.sv
// ID-side bundle of the forwarding scoreboard: decoded operands in, stall and selects out.
interface fwd_scoreboard_unit_if #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = fwd_pkg::RD_W,
    parameter int FWD_SEL_W  = 2
) ();

    logic                          id_valid;
    logic                          id_reg_write;
    logic                          id_is_mul;
    logic [REG_ADDR_W-1:0]         id_rd;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]            id_src_used;
    logic                          flush;
    logic                          stall;
    logic [NUM_SRC*FWD_SEL_W-1:0]  fwd_sel_q;

    modport master (
        output id_valid, id_reg_write, id_is_mul, id_rd,
        output id_src, id_src_used, flush,
        input  stall, fwd_sel_q
    );

    modport slave (
        input  id_valid, id_reg_write, id_is_mul, id_rd,
        input  id_src, id_src_used, flush,
        output stall, fwd_sel_q
    );

endinterface

// File: rtl/fwd_src_match.sv
// Per-source producer search: youngest matching in-flight writer decides select or stall.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int MUL_LAT = 3,
    parameter int SEL_W   = 2
) (
    input  sb_entry_t [DEPTH-1:0] ents,
    input  logic [RD_W-1:0]       src,
    input  logic                  used,
    output logic [SEL_W-1:0]      sel,
    output logic                  need_stall
);

    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        sel        = SEL_W'(FWD_SEL_RF);
        need_stall = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && ents[k].v && ents[k].wr &&
                ents[k].rd != '0 && ents[k].rd == src) begin
                if (k + 1 >= (ents[k].mul ? MUL_LAT : LAT_ALU)) begin
                    sel        = SEL_W'(k + 1);
                    need_stall = 1'b0;
                end else begin
                    sel        = SEL_W'(FWD_SEL_RF);
                    need_stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding scoreboard between ID and EX; tracks writers EX..WB incl. multi-cycle MUL.
// Optional `FWD_STATS_EN adds saturating stall/forward counters.
module fwd_scoreboard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = RD_W,
    parameter int MUL_LAT    = 3
) (
    input  logic clk,
    input  logic arst,
    fwd_scoreboard_unit_if.slave sb
`ifdef FWD_STATS_EN
    ,
    output logic [31:0] stall_cnt_q,
    output logic [31:0] fwd_cnt_q
`endif
);

    localparam int DEPTH     = MUL_LAT;
    localparam int FWD_SEL_W = $clog2(MUL_LAT + 1);

    sb_entry_t [DEPTH-1:0]        ents_q;
    sb_entry_t                    e_in;
    logic [NUM_SRC-1:0]           need;
    logic [NUM_SRC*FWD_SEL_W-1:0] sel;
    logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel_q;
    logic                         stall;
    logic                         bubble;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_match #(
            .DEPTH   (DEPTH),
            .MUL_LAT (MUL_LAT),
            .SEL_W   (FWD_SEL_W)
        ) u_match (
            .ents       (ents_q),
            .src        (sb.id_src[s*REG_ADDR_W +: REG_ADDR_W]),
            .used       (sb.id_src_used[s]),
            .sel        (sel[s*FWD_SEL_W +: FWD_SEL_W]),
            .need_stall (need[s])
        );
    end

    assign stall  = sb.id_valid & ~sb.flush & (|need);
    assign bubble = sb.flush | stall;

    always_comb begin
        e_in = '0;
        if (!bubble) begin
            e_in.v   = sb.id_valid;
            e_in.wr  = sb.id_reg_write;
            e_in.mul = sb.id_is_mul;
            e_in.rd  = sb.id_rd;
        end
    end

    // Back end never stalls: entries advance every cycle, oldest retires to the regfile.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ents_q    <= '0;
            fwd_sel_q <= '0;
        end else begin
            ents_q    <= {ents_q[DEPTH-2:0], e_in};
            fwd_sel_q <= bubble ? '0 : sel;
        end
    end

    assign sb.stall     = stall;
    assign sb.fwd_sel_q = fwd_sel_q;

`ifdef FWD_STATS_EN
    logic accept_fwd;

    assign accept_fwd = sb.id_valid & ~bubble & (|sel);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (accept_fwd && fwd_cnt_q != '1)
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Bench for fwd_scoreboard_unit: timestamp model checked every cycle plus directed literal checks.
module tb_fwd_scoreboard_unit;

    localparam int MUL_LAT = 3;

    logic clk;
    logic arst;
    int   errors;
    int   checks;
    int   cyc;

    fwd_scoreboard_unit_if #(
        .NUM_SRC    (2),
        .REG_ADDR_W (5),
        .FWD_SEL_W  (2)
    ) sbif ();

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    int          m_stall_cnt;
    int          m_fwd_cnt;
`endif

    fwd_scoreboard_unit #(
        .NUM_SRC    (2),
        .REG_ADDR_W (5),
        .MUL_LAT    (MUL_LAT)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .sb   (sbif)
`ifdef FWD_STATS_EN
        ,
        .stall_cnt_q (stall_cnt_q),
        .fwd_cnt_q   (fwd_cnt_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: accepted instructions with the cycle they entered EX.
    typedef struct {
        int         issue;
        logic       wr;
        logic       mul;
        logic [4:0] rd;
    } rec_t;

    rec_t       q[$];
    logic [3:0] exp_q;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, got, exp, $time);
        end
    endtask

    function automatic void model_eval(output logic st,
                                       output logic [3:0] sl);
        logic need;
        need = 1'b0;
        sl   = '0;
        for (int s = 0; s < 2; s++) begin
            automatic logic [4:0] src = sbif.id_src[s*5 +: 5];
            automatic int best = -1;
            automatic int bi   = 0;
            foreach (q[i]) begin
                automatic int age = cyc - q[i].issue;
                if (age < MUL_LAT && q[i].wr && q[i].rd != 0 &&
                    q[i].rd == src && sbif.id_src_used[s] &&
                    (best < 0 || age < best)) begin
                    best = age;
                    bi   = i;
                end
            end
            if (best >= 0) begin
                if (best + 1 >= (q[bi].mul ? MUL_LAT : 1))
                    sl[s*2 +: 2] = 2'(best + 1);
                else
                    need = 1'b1;
            end
        end
        st = sbif.id_valid & ~sbif.flush & need;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            q.delete();
            cyc   = 0;
            exp_q = '0;
`ifdef FWD_STATS_EN
            m_stall_cnt = 0;
            m_fwd_cnt   = 0;
`endif
        end else begin
            logic       st;
            logic [3:0] sl;
            model_eval(st, sl);
            cyc++;
            if (sbif.flush || st) begin
                exp_q = '0;
            end else begin
                exp_q = sl;
                if (sbif.id_valid)
                    q.push_back('{cyc, sbif.id_reg_write,
                                  sbif.id_is_mul, sbif.id_rd});
            end
`ifdef FWD_STATS_EN
            if (st)
                m_stall_cnt++;
            if (sbif.id_valid && !sbif.flush && !st && sl != 0)
                m_fwd_cnt++;
`endif
            while (q.size() > 0 && cyc - q[0].issue >= MUL_LAT)
                void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!arst) begin
            logic       st;
            logic [3:0] sl;
            model_eval(st, sl);
            chk("model_stall", {31'd0, sbif.stall}, {31'd0, st});
            chk("model_fwd_sel_q", {28'd0, sbif.fwd_sel_q}, {28'd0, exp_q});
`ifdef FWD_STATS_EN
            chk("model_stall_cnt", stall_cnt_q, m_stall_cnt);
            chk("model_fwd_cnt", fwd_cnt_q, m_fwd_cnt);
`endif
        end
    end

    task automatic drive(input logic v, input logic wr, input logic mul,
                         input logic [4:0] rd, input logic [4:0] s0,
                         input logic [4:0] s1, input logic [1:0] used,
                         input logic fl);
        sbif.id_valid     = v;
        sbif.id_reg_write = wr;
        sbif.id_is_mul    = mul;
        sbif.id_rd        = rd;
        sbif.id_src       = {s1, s0};
        sbif.id_src_used  = used;
        sbif.flush        = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FWD_STATS_EN
        int base_st;
        int base_fw;
`endif
        errors = 0;
        checks = 0;
        arst   = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
        #12;
        chk("reset_stall", {31'd0, sbif.stall}, 32'd0);
        chk("reset_sel", {28'd0, sbif.fwd_sel_q}, 32'd0);
`ifdef FWD_STATS_EN
        chk("reset_stall_cnt", stall_cnt_q, 32'd0);
`endif
        arst = 1'b0;
        tick();

        // ALU x5 then reader src0=x5
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 1'b0);
        #1 chk("alu_no_stall", {31'd0, sbif.stall}, 32'd0);
        tick();
        chk("alu_sel1", {30'd0, sbif.fwd_sel_q[1:0]}, 32'd1);
        nop(3);

        // MUL x7 then reader src1=x7: two stall cycles, then sel 3
`ifdef FWD_STATS_EN
        base_st = stall_cnt_q;
        base_fw = fwd_cnt_q;
`endif
        drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 2'b10, 1'b0);
        #1 chk("mul_stall_c1", {31'd0, sbif.stall}, 32'd1);
        tick();
        chk("mul_stall_c2", {31'd0, sbif.stall}, 32'd1);
        chk("mul_bubble_sel", {28'd0, sbif.fwd_sel_q}, 32'd0);
        tick();
        chk("mul_stall_end", {31'd0, sbif.stall}, 32'd0);
        tick();
        chk("mul_sel3", {30'd0, sbif.fwd_sel_q[3:2]}, 32'd3);
`ifdef FWD_STATS_EN
        chk("stats_stall_cnt", stall_cnt_q - base_st, 32'd2);
        chk("stats_fwd_cnt", fwd_cnt_q - base_fw, 32'd1);
`endif
        nop(3);

        // Two writers of x3: youngest wins
        drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0);
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 2'b01, 1'b0);
        tick();
        chk("youngest_sel1", {30'd0, sbif.fwd_sel_q[1:0]}, 32'd1);
        nop(3);
        drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b0);
        tick();
        nop(1);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 2'b01, 1'b0);
        tick();
        chk("older_sel2", {30'd0, sbif.fwd_sel_q[1:0]}, 32'd2);
        nop(3);

        // rd=x0 and unused sources never forward or stall
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0);
        #1 chk("x0_no_stall", {31'd0, sbif.stall}, 32'd0);
        tick();
        chk("x0_sel0", {28'd0, sbif.fwd_sel_q}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 2'b00, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd9, 5'd9, 2'b00, 1'b0);
        #1 chk("unused_no_stall", {31'd0, sbif.stall}, 32'd0);
        tick();
        chk("unused_sel0", {28'd0, sbif.fwd_sel_q}, 32'd0);
        nop(3);

        // Flush during a MUL stall
        drive(1'b1, 1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 2'b00, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 2'b01, 1'b0);
        #1 chk("flush_pre_stall", {31'd0, sbif.stall}, 32'd1);
        sbif.flush = 1'b1;
        #1 chk("flush_stall0", {31'd0, sbif.stall}, 32'd0);
        tick();
        chk("flush_bubble_sel", {28'd0, sbif.fwd_sel_q}, 32'd0);
        nop(3);

        // Async reset during a MUL stall with a live forward select
        drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 5'd0, 2'b00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'd6, 5'd8, 5'd0, 2'b01, 1'b0);
        tick();
        chk("rst_pre_sel1", {30'd0, sbif.fwd_sel_q[1:0]}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, 2'b10, 1'b0);
        #1 chk("rst_pre_stall", {31'd0, sbif.stall}, 32'd1);
        arst = 1'b1;
        #1;
        chk("rst_stall0", {31'd0, sbif.stall}, 32'd0);
        chk("rst_sel0", {28'd0, sbif.fwd_sel_q}, 32'd0);
        #3 arst = 1'b0;
        #1 chk("rst_empty_stall", {31'd0, sbif.stall}, 32'd0);
        tick();
        chk("rst_empty_sel", {28'd0, sbif.fwd_sel_q}, 32'd0);
        nop(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
